rob_complete_arbiter: RTL and testbench

- Shares the ROB's three completion ports among NUM_REQ functional-unit result producers (ALUs, load unit, branch unit).
- Each cycle it grants up to three pending results in round-robin order.
- Granted results are registered onto the ROB's en_complete_instr0/1/2, complete_indx, complete_pc and complete_val inputs.
- Sits between functional-unit writeback stages and the reorder buffer.

---
 rtl/rob_complete_arbiter.sv | 139 +++++++++++++
 tb/tb_rob_complete_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rob_complete_arbiter.sv
// Round-robin arbiter that packs up to three functional-unit results per cycle
// onto the ROB's three registered completion ports.
module rob_complete_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int ROB_SIZE  = 16,
    parameter int PC_SIZE   = 32,
    parameter int WORD_SIZE = 32,
    parameter int CNT_SIZE  = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ*$clog2(ROB_SIZE)-1:0] req_indx_i,
    input  logic [NUM_REQ*PC_SIZE-1:0]         req_pc_i,
    input  logic [NUM_REQ*WORD_SIZE-1:0]       req_val_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic                               en_complete_instr0_o,
    output logic                               en_complete_instr1_o,
    output logic                               en_complete_instr2_o,
    output logic [$clog2(ROB_SIZE)-1:0]        complete_indx0_o,
    output logic [$clog2(ROB_SIZE)-1:0]        complete_indx1_o,
    output logic [$clog2(ROB_SIZE)-1:0]        complete_indx2_o,
    output logic [PC_SIZE-1:0]                 complete_pc0_o,
    output logic [PC_SIZE-1:0]                 complete_pc1_o,
    output logic [PC_SIZE-1:0]                 complete_pc2_o,
    output logic [WORD_SIZE-1:0]               complete_val0_o,
    output logic [WORD_SIZE-1:0]               complete_val1_o,
    output logic [WORD_SIZE-1:0]               complete_val2_o,
    output logic                               dup_indx_err_o,
    output logic [CNT_SIZE-1:0]                complete_cnt_o
);
    localparam int IW = $clog2(ROB_SIZE);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        next_ptr;
    logic [PW-1:0]        last_grant;
    logic [1:0]           n_grant;
    logic [PW-1:0]        slot_sel [3];
    logic [2:0]           slot_vld;
    logic [IW-1:0]        slot_indx [3];
    logic [PC_SIZE-1:0]   slot_pc [3];
    logic [WORD_SIZE-1:0] slot_val [3];
    logic                 dup_now;
    logic [CNT_SIZE:0]    cnt_sum;

    logic                 en_q [3];
    logic [IW-1:0]        indx_q [3];
    logic [PC_SIZE-1:0]   pc_q [3];
    logic [WORD_SIZE-1:0] val_q [3];
    logic                 dup_q;
    logic [CNT_SIZE-1:0]  cnt_q;

    // Scan from rr_ptr with wraparound; the n-th grant in scan order lands on port n.
    always_comb begin
        req_ready_o = '0;
        n_grant     = 2'd0;
        slot_vld    = 3'b000;
        last_grant  = rr_ptr;
        for (int j = 0; j < 3; j++) begin
            slot_sel[j] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = int'(rr_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (req_valid_i[k] && (n_grant != 2'd3) && !flush_i && !rst_i) begin
                req_ready_o[k] = 1'b1;
                case (n_grant)
                    2'd0: begin slot_sel[0] = PW'(k); slot_vld[0] = 1'b1; end
                    2'd1: begin slot_sel[1] = PW'(k); slot_vld[1] = 1'b1; end
                    default: begin slot_sel[2] = PW'(k); slot_vld[2] = 1'b1; end
                endcase
                n_grant    = n_grant + 2'd1;
                last_grant = PW'(k);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            slot_indx[j] = req_indx_i[int'(slot_sel[j])*IW +: IW];
            slot_pc[j]   = req_pc_i[int'(slot_sel[j])*PC_SIZE +: PC_SIZE];
            slot_val[j]  = req_val_i[int'(slot_sel[j])*WORD_SIZE +: WORD_SIZE];
        end
        dup_now = (slot_vld[0] && slot_vld[1] && (slot_indx[0] == slot_indx[1])) ||
                  (slot_vld[0] && slot_vld[2] && (slot_indx[0] == slot_indx[2])) ||
                  (slot_vld[1] && slot_vld[2] && (slot_indx[1] == slot_indx[2]));
        next_ptr = (int'(last_grant) == NUM_REQ - 1) ? '0 : last_grant + PW'(1);
        cnt_sum  = {1'b0, cnt_q} + (CNT_SIZE+1)'(n_grant);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            dup_q  <= 1'b0;
            cnt_q  <= '0;
            for (int j = 0; j < 3; j++) begin
                en_q[j]   <= 1'b0;
                indx_q[j] <= '0;
                pc_q[j]   <= '0;
                val_q[j]  <= '0;
            end
        end else begin
            if (n_grant != 2'd0) begin
                rr_ptr <= next_ptr;
            end
            dup_q <= dup_q | dup_now;
            cnt_q <= cnt_sum[CNT_SIZE] ? '1 : cnt_sum[CNT_SIZE-1:0];
            // Idle ports keep their last payload; only the enable drops.
            for (int j = 0; j < 3; j++) begin
                en_q[j] <= slot_vld[j];
                if (slot_vld[j]) begin
                    indx_q[j] <= slot_indx[j];
                    pc_q[j]   <= slot_pc[j];
                    val_q[j]  <= slot_val[j];
                end
            end
        end
    end

    assign en_complete_instr0_o = en_q[0];
    assign en_complete_instr1_o = en_q[1];
    assign en_complete_instr2_o = en_q[2];
    assign complete_indx0_o     = indx_q[0];
    assign complete_indx1_o     = indx_q[1];
    assign complete_indx2_o     = indx_q[2];
    assign complete_pc0_o       = pc_q[0];
    assign complete_pc1_o       = pc_q[1];
    assign complete_pc2_o       = pc_q[2];
    assign complete_val0_o      = val_q[0];
    assign complete_val1_o      = val_q[1];
    assign complete_val2_o      = val_q[2];
    assign dup_indx_err_o       = dup_q;
    assign complete_cnt_o       = cnt_q;
endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Directed bench for rob_complete_arbiter: expected port contents are queued per grant
// and a monitor compares them whenever a completion enable is presented.
module tb_rob_complete_arbiter;
    localparam int NR = 5;
    localparam int IW = 4;
    localparam int PW = 32;
    localparam int WW = 32;
    localparam int CW = 5;
    localparam int EW = 3 + 3*IW + 3*PW + 3*WW + CW + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              flush_i = 1'b0;
    logic [NR-1:0]     req_valid_i = '0;
    logic [NR*IW-1:0]  req_indx_i = '0;
    logic [NR*PW-1:0]  req_pc_i = '0;
    logic [NR*WW-1:0]  req_val_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic              en0, en1, en2;
    logic [IW-1:0]     indx0, indx1, indx2;
    logic [PW-1:0]     pc0, pc1, pc2;
    logic [WW-1:0]     val0, val1, val2;
    logic              dup_err;
    logic [CW-1:0]     cnt;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    logic [IW-1:0] d_indx [NR];
    logic [PW-1:0] d_pc [NR];
    logic [WW-1:0] d_val [NR];
    logic [IW-1:0] h_indx [3];
    logic [PW-1:0] h_pc [3];
    logic [WW-1:0] h_val [3];
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_dup = 1'b0;

    rob_complete_arbiter #(
        .NUM_REQ(NR), .ROB_SIZE(16), .PC_SIZE(PW), .WORD_SIZE(WW), .CNT_SIZE(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_indx_i(req_indx_i),
        .req_pc_i(req_pc_i), .req_val_i(req_val_i), .req_ready_o(req_ready_o),
        .en_complete_instr0_o(en0), .en_complete_instr1_o(en1), .en_complete_instr2_o(en2),
        .complete_indx0_o(indx0), .complete_indx1_o(indx1), .complete_indx2_o(indx2),
        .complete_pc0_o(pc0), .complete_pc1_o(pc1), .complete_pc2_o(pc2),
        .complete_val0_o(val0), .complete_val1_o(val1), .complete_val2_o(val2),
        .dup_indx_err_o(dup_err), .complete_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] dut_vec();
        return {en0, en1, en2, indx0, indx1, indx2, pc0, pc1, pc2, val0, val1, val2, cnt, dup_err};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Default payload: distinct ROB indices per requester within a step.
    task automatic fill(input int sn);
        for (int k = 0; k < NR; k++) begin
            d_indx[k] = IW'((k*3 + sn) % 16);
            d_pc[k]   = 32'h1000 + 32'(sn*16 + k);
            d_val[k]  = 32'(sn*256 + k);
        end
    endtask

    task automatic step(input string name, input logic [NR-1:0] valid, input logic flush,
                        input logic [NR-1:0] exp_ready, input int p0, input int p1, input int p2);
        int p[3];
        int n;
        logic [2:0] e;
        logic [CW:0] s;
        p[0] = p0; p[1] = p1; p[2] = p2;
        @(negedge clk);
        rst_i       = 1'b0;
        flush_i     = flush;
        req_valid_i = valid;
        for (int k = 0; k < NR; k++) begin
            req_indx_i[k*IW +: IW] = d_indx[k];
            req_pc_i[k*PW +: PW]   = d_pc[k];
            req_val_i[k*WW +: WW]  = d_val[k];
        end
        #1;
        check({name, " ready"}, EW'(req_ready_o), EW'(exp_ready));
        n = 0;
        e = 3'b000;
        for (int j = 0; j < 3; j++) begin
            if (p[j] >= 0) begin
                e[2-j]    = 1'b1;
                h_indx[j] = d_indx[p[j]];
                h_pc[j]   = d_pc[p[j]];
                h_val[j]  = d_val[p[j]];
                n++;
            end
        end
        for (int a = 0; a < 3; a++)
            for (int b = a + 1; b < 3; b++)
                if (p[a] >= 0 && p[b] >= 0 && d_indx[p[a]] == d_indx[p[b]])
                    exp_dup = 1'b1;
        s = {1'b0, exp_cnt} + (CW+1)'(n);
        exp_cnt = s[CW] ? CNT_MAX : s[CW-1:0];
        if (n > 0) begin
            exp_q.push_back({e, h_indx[0], h_indx[1], h_indx[2], h_pc[0], h_pc[1], h_pc[2],
                             h_val[0], h_val[1], h_val[2], exp_cnt, exp_dup});
        end else begin
            @(posedge clk);
            #1;
            check({name, " idle"}, dut_vec(),
                  {3'b000, h_indx[0], h_indx[1], h_indx[2], h_pc[0], h_pc[1], h_pc[2],
                   h_val[0], h_val[1], h_val[2], exp_cnt, exp_dup});
        end
    endtask

    task automatic do_reset(input string name, input logic [NR-1:0] valid);
        @(negedge clk);
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = valid;
        #1;
        check({name, " ready"}, EW'(req_ready_o), EW'(0));
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            h_indx[j] = '0; h_pc[j] = '0; h_val[j] = '0;
        end
        exp_cnt = '0;
        exp_dup = 1'b0;
        check({name, " outputs"}, dut_vec(), EW'(0));
    endtask

    // Monitor: every presented completion must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (en0 || en1 || en2) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got %h expected none", dut_vec());
            end else begin
                check("completion", dut_vec(), exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int j = 0; j < 3; j++) begin
            h_indx[j] = '0; h_pc[j] = '0; h_val[j] = '0;
        end
        do_reset("reset0", '0);
        do_reset("reset1", '0);

        fill(1); d_indx[0] = 4'd3; d_pc[0] = 32'h40; d_val[0] = 32'd7;
        step("single", 5'b00001, 1'b0, 5'b00001, 0, -1, -1);
        fill(2);  step("req4_only", 5'b10000, 1'b0, 5'b10000, 4, -1, -1);
        fill(3);  step("all_a", 5'b11111, 1'b0, 5'b00111, 0, 1, 2);
        fill(4);  step("all_b", 5'b11111, 1'b0, 5'b11001, 3, 4, 0);
        fill(5);  step("all_c", 5'b11111, 1'b0, 5'b01110, 1, 2, 3);
        fill(6);  step("req1_only", 5'b00010, 1'b0, 5'b00010, 1, -1, -1);
        fill(7);  step("wrap_pair", 5'b10010, 1'b0, 5'b10010, 4, 1, -1);
        fill(8);  step("flush", 5'b11111, 1'b1, 5'b00000, -1, -1, -1);
        fill(9);  step("post_flush", 5'b11111, 1'b0, 5'b11100, 2, 3, 4);
        fill(10); d_indx[0] = 4'd5; d_indx[1] = 4'd5;
        step("dup", 5'b00011, 1'b0, 5'b00011, 0, 1, -1);
        fill(11); step("idle_sticky", 5'b00000, 1'b0, 5'b00000, -1, -1, -1);
        fill(12); step("all_d", 5'b11111, 1'b0, 5'b11100, 2, 3, 4);
        fill(13); step("all_e", 5'b11111, 1'b0, 5'b00111, 0, 1, 2);
        fill(14); step("all_f", 5'b11111, 1'b0, 5'b11001, 3, 4, 0);
        fill(15); step("all_g", 5'b11111, 1'b0, 5'b01110, 1, 2, 3);
        fill(16); step("saturate", 5'b11111, 1'b0, 5'b10011, 4, 0, 1);
        fill(17); step("sat_hold", 5'b01010, 1'b0, 5'b01010, 3, 1, -1);
        do_reset("reset_mid", 5'b00111);
        fill(18); step("after_reset", 5'b10001, 1'b0, 5'b10001, 0, 4, -1);
        fill(19); step("drain", 5'b00000, 1'b0, 5'b00000, -1, -1, -1);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
